// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a registered response slot per requester. ALU_SHARE_PERF_EN adds grant/conflict counters.
module alu_share_arbiter #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_in0,
  input  logic [DATA_W-1:0]  req0_in1,
  input  logic [CTRL_W-1:0]  req0_ctrl,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_in0,
  input  logic [DATA_W-1:0]  req1_in1,
  input  logic [CTRL_W-1:0]  req1_ctrl,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic               resp0_valid,
  input  logic               resp0_ready,
  output logic [DATA_W-1:0]  resp0_result,
  output logic               resp0_zero,
  output logic               resp1_valid,
  input  logic               resp1_ready,
  output logic [DATA_W-1:0]  resp1_result,
  output logic               resp1_zero,
  output logic [DATA_W-1:0]  alu_in0,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic [SHAMT_W-1:0] alu_shamt,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero
`ifdef ALU_SHARE_PERF_EN
  ,
  output logic [15:0]        perf_grant0,
  output logic [15:0]        perf_grant1,
  output logic [15:0]        perf_conflict
`endif
);

  logic [1:0]             req_vld, resp_rdy, elig, grant, slot_vld, slot_zero;
  logic [1:0][DATA_W-1:0] slot_res;
  logic                   rr_last;

  assign req_vld  = {req1_valid, req0_valid};
  assign resp_rdy = {resp1_ready, resp0_ready};

  // A full slot is only eligible when its consumer drains it this same cycle.
  assign elig = req_vld & (~slot_vld | resp_rdy);

  assign grant[0] = elig[0] & (~elig[1] | rr_last);
  assign grant[1] = elig[1] & (~elig[0] | ~rr_last);

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    alu_in0   = '0;
    alu_in1   = '0;
    alu_ctrl  = '0;
    alu_shamt = '0;
    if (grant[0]) begin
      alu_in0   = req0_in0;
      alu_in1   = req0_in1;
      alu_ctrl  = req0_ctrl;
      alu_shamt = req0_shamt;
    end else if (grant[1]) begin
      alu_in0   = req1_in0;
      alu_in1   = req1_in1;
      alu_ctrl  = req1_ctrl;
      alu_shamt = req1_shamt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld  <= '0;
      slot_res  <= '0;
      slot_zero <= '0;
      rr_last   <= 1'b1;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (grant[n]) begin
          slot_vld[n]  <= 1'b1;
          slot_res[n]  <= alu_result;
          slot_zero[n] <= alu_zero;
        end else if (resp_rdy[n]) begin
          slot_vld[n]  <= 1'b0;
        end
      end
      if (grant[0])      rr_last <= 1'b0;
      else if (grant[1]) rr_last <= 1'b1;
    end
  end

  assign resp0_valid  = slot_vld[0];
  assign resp0_result = slot_res[0];
  assign resp0_zero   = slot_zero[0];
  assign resp1_valid  = slot_vld[1];
  assign resp1_result = slot_res[1];
  assign resp1_zero   = slot_zero[1];

`ifdef ALU_SHARE_PERF_EN
  logic conflict;
  assign conflict = req0_valid & req1_valid & (grant[0] | grant[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (grant[0] && perf_grant0 != 16'hFFFF)   perf_grant0   <= perf_grant0 + 16'd1;
      if (grant[1] && perf_grant1 != 16'hFFFF)   perf_grant1   <= perf_grant1 + 16'd1;
      if (conflict && perf_conflict != 16'hFFFF) perf_conflict <= perf_conflict + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: stimulus pushes hand-computed responses
// into per-requester queues, a negedge monitor pops and compares on each drain.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_in0, req0_in1, req1_in0, req1_in1;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        resp0_valid, resp0_ready, resp0_zero;
  logic        resp1_valid, resp1_ready, resp1_zero;
  logic [31:0] resp0_result, resp1_result;
  logic [31:0] alu_in0, alu_in1, alu_result;
  logic [3:0]  alu_ctrl;
  logic [4:0]  alu_shamt;
  logic        alu_zero;
`ifdef ALU_SHARE_PERF_EN
  logic [15:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] e0, e1;
  int g;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in0(req0_in0),
    .req0_in1(req0_in1), .req0_ctrl(req0_ctrl), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in0(req1_in0),
    .req1_in1(req1_in1), .req1_ctrl(req1_ctrl), .req1_shamt(req1_shamt),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result), .resp0_zero(resp0_zero),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result), .resp1_zero(resp1_zero),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_ctrl(alu_ctrl),
    .alu_shamt(alu_shamt), .alu_result(alu_result), .alu_zero(alu_zero)
`ifdef ALU_SHARE_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
    .perf_conflict(perf_conflict)
`endif
  );

  // Bench ALU: and/or/add/sll/sub/slt
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_in0 & alu_in1;
      4'b0001: alu_result = alu_in0 | alu_in1;
      4'b0010: alu_result = alu_in0 + alu_in1;
      4'b0011: alu_result = alu_in1 << alu_shamt;
      4'b0110: alu_result = alu_in0 - alu_in1;
      4'b0111: alu_result = ($signed(alu_in0) < $signed(alu_in1)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (resp0_valid && resp0_ready) begin
        if (q0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL resp0_unexpected: got %0h expected none", resp0_result);
        end else begin
          e0 = q0.pop_front();
          chk("resp0_result", resp0_result, e0[31:0]);
          chk("resp0_zero", {31'd0, resp0_zero}, {31'd0, e0[32]});
        end
      end
      if (resp1_valid && resp1_ready) begin
        if (q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL resp1_unexpected: got %0h expected none", resp1_result);
        end else begin
          e1 = q1.pop_front();
          chk("resp1_result", resp1_result, e1[31:0]);
          chk("resp1_zero", {31'd0, resp1_zero}, {31'd0, e1[32]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_in0 = 0; req0_in1 = 0; req0_ctrl = 0; req0_shamt = 0;
    req1_valid = 0; req1_in0 = 0; req1_in1 = 0; req1_ctrl = 0; req1_shamt = 0;
    resp0_ready = 0; resp1_ready = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_resp0_valid", {31'd0, resp0_valid}, 0);
    chk("rst_resp1_valid", {31'd0, resp1_valid}, 0);
    chk("rst_resp0_result", resp0_result, 0);
    chk("rst_resp1_zero", {31'd0, resp1_zero}, 0);

    // Single op: 5 + 3
    cyc(); rst = 0;
    req0_valid = 1; req0_in0 = 5; req0_in1 = 3; req0_ctrl = 4'b0010; resp0_ready = 1;
    q0.push_back({1'b0, 32'd8});
    @(negedge clk);
    chk("single_req0_ready", {31'd0, req0_ready}, 1);
    chk("single_req1_ready", {31'd0, req1_ready}, 0);
    chk("single_alu_in0", alu_in0, 5);
    chk("single_alu_ctrl", {28'd0, alu_ctrl}, 2);
    cyc(); req0_valid = 0;
    @(negedge clk);
    chk("single_resp0_valid", {31'd0, resp0_valid}, 1);
    chk("idle_alu_in0", alu_in0, 0);
    cyc();
    @(negedge clk);
    chk("drained_resp0_valid", {31'd0, resp0_valid}, 0);

    // Contention: rr_last=0 after the single op, so req1 goes first
    cyc();
    req0_valid = 1; req0_in0 = 7; req0_in1 = 7; req0_ctrl = 4'b0110;
    req1_valid = 1; req1_in0 = 32'hF0; req1_in1 = 32'h0F; req1_ctrl = 4'b0001;
    resp1_ready = 1;
    g = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("cont_req0_ready", {31'd0, req0_ready}, (g == 0) ? 1 : 0);
      chk("cont_req1_ready", {31'd0, req1_ready}, (g == 1) ? 1 : 0);
      if (g == 0) q0.push_back({1'b1, 32'd0});
      else        q1.push_back({1'b0, 32'hFF});
      g = 1 - g;
      cyc();
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    cyc();

    // Backpressure on slot 0; req1 keeps flowing
    resp0_ready = 0;
    req0_valid = 1; req0_in0 = 0; req0_in1 = 1; req0_shamt = 4; req0_ctrl = 4'b0011;
    @(negedge clk);
    chk("bp_first_accept", {31'd0, req0_ready}, 1);
    q0.push_back({1'b0, 32'd16});
    cyc();
    req0_in1 = 2;
    req1_valid = 1; req1_in0 = 2; req1_in1 = 3; req1_ctrl = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_req0_stall", {31'd0, req0_ready}, 0);
      chk("bp_req1_ready", {31'd0, req1_ready}, 1);
      chk("bp_resp0_valid", {31'd0, resp0_valid}, 1);
      chk("bp_resp0_held", resp0_result, 16);
      q1.push_back({1'b0, 32'd5});
      cyc();
    end
    resp0_ready = 1;
    @(negedge clk);
    chk("bp_release_req0", {31'd0, req0_ready}, 1);
    chk("bp_release_req1", {31'd0, req1_ready}, 0);
    q0.push_back({1'b0, 32'd32});
    cyc();
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("bp_second_valid", {31'd0, resp0_valid}, 1);
    cyc();

    // Same-cycle drain and refill of slot 0
    resp0_ready = 0;
    req0_valid = 1; req0_in0 = 1; req0_in1 = 1; req0_shamt = 0; req0_ctrl = 4'b0010;
    @(negedge clk);
    chk("dr_fill_accept", {31'd0, req0_ready}, 1);
    q0.push_back({1'b0, 32'd2});
    cyc();
    resp0_ready = 1;
    req0_in0 = 32'hFFFF_FFFF; req0_in1 = 1; req0_ctrl = 4'b0111;
    @(negedge clk);
    chk("dr_full_valid", {31'd0, resp0_valid}, 1);
    chk("dr_refill_accept", {31'd0, req0_ready}, 1);
    q0.push_back({1'b0, 32'd1});
    cyc();
    req0_valid = 0;
    @(negedge clk);
    chk("dr_slt_valid", {31'd0, resp0_valid}, 1);
    cyc();

    // Fill both slots, then reset
    resp0_ready = 0; resp1_ready = 0;
    req0_valid = 1; req0_in0 = 32'hFF; req0_in1 = 32'h0F; req0_ctrl = 4'b0000;
    req1_valid = 1; req1_in0 = 5; req1_in1 = 6; req1_ctrl = 4'b0010;
    @(negedge clk);
    chk("rm_req1_first", {31'd0, req1_ready}, 1);
    chk("rm_req0_wait", {31'd0, req0_ready}, 0);
    cyc(); req1_valid = 0;
    @(negedge clk);
    chk("rm_req0_second", {31'd0, req0_ready}, 1);
    cyc(); req0_valid = 0;
    @(negedge clk);
    chk("rm_full0", {31'd0, resp0_valid}, 1);
    chk("rm_full1", {31'd0, resp1_valid}, 1);
    cyc(); rst = 1;
    cyc(); rst = 0;
    @(negedge clk);
    chk("rm_resp0_valid", {31'd0, resp0_valid}, 0);
    chk("rm_resp1_valid", {31'd0, resp1_valid}, 0);
    chk("rm_resp0_result", resp0_result, 0);
    cyc();

    // Contention after reset: req0 must win first
    req1_in0 = 32'hFFFF_FFFF; req1_in1 = 1;
    req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
    g = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_req0_ready", {31'd0, req0_ready}, (g == 0) ? 1 : 0);
      chk("post_rst_req1_ready", {31'd0, req1_ready}, (g == 1) ? 1 : 0);
      if (g == 0) q0.push_back({1'b0, 32'h0F});
      else        q1.push_back({1'b1, 32'd0});
      g = 1 - g;
      cyc();
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
`ifdef ALU_SHARE_PERF_EN
    chk("perf_grant0", {16'd0, perf_grant0}, 5);
    chk("perf_grant1", {16'd0, perf_grant1}, 5);
    chk("perf_conflict", {16'd0, perf_conflict}, 10);
`endif
    cyc();
    @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
